prv32_id_ex_stage: RTL and testbench
====================================

Name: prv32_id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined RV32 core, directly upstream of the ALU.
- Captures decoded operands and control from ID and resolves operand forwarding from EX/MEM and MEM/WB; drives the ALU a/b/alufn inputs and the store data.
- Detects load-use hazards and inserts bubbles on stall or branch flush.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- CTRL_W, 8, opaque control bundle width; bit0 = reg_write, bit1 = mem_read.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  decoded immediate.
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses.
- id_alufn  in  4  ALU function code.
- id_a_sel_pc  in  1  ALU a = PC instead of rs1.
- id_b_sel_imm  in  1  ALU b = imm instead of rs2.
- id_ctrl  in  CTRL_W  downstream control bundle.
- flush  in  1  taken branch/jump resolved; kill ID/EX contents.
- mem_rd  in  RA_W  EX/MEM destination register.
- mem_reg_write  in  1  EX/MEM instruction writes a register.
- mem_result  in  XLEN  EX/MEM ALU result.
- wb_rd  in  RA_W  MEM/WB destination register.
- wb_reg_write  in  1  MEM/WB instruction writes a register.
- wb_data  in  XLEN  write-back data.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rd  out  RA_W  registered destination.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_alufn  out  4  registered function code, to ALU.
- alu_a, alu_b  out  XLEN  forwarded ALU operands.
- ex_store_data  out  XLEN  forwarded rs2 value, for stores.

Behaviour:
- Reset (rst high at posedge): ex_valid=0, ex_ctrl=0, ex_rd=0, ex_alufn=0, ex_pc=0; registered data/imm/addresses=0.
- Consequence of reset: alu_a=0, alu_b=0, ex_store_data=0 until the first capture, since no forwarding matches while reg_write inputs are low.
- Register update priority at each posedge (not in reset):
  - flush → bubble.
  - else stall → bubble.
  - else capture all id_* fields; ex_valid=id_valid; ex_ctrl=id_ctrl gated to 0 when !id_valid.
- Bubble: ex_valid=0, ex_ctrl=0, ex_rd=0; the data registers may hold any value.
- Latency: 1 cycle from ID to EX outputs.
- Capture-time WB bypass: on capture, if wb_reg_write && wb_rd!=0 && wb_rd==id_rsN, register wb_data in place of id_rsN_data (N=1,2).
- Load-use detection: raw_lu = id_valid && ex_valid && ex_ctrl[1] && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - rs2 is compared unconditionally, even when id_b_sel_imm is set.
- stall = raw_lu && !flush. Flush takes precedence so the fetch redirect is never held.
- EX forwarding, combinational on the registered rsN (x0 is never forwarded):
  - Source 1: mem_result, if mem_reg_write && mem_rd==rsN.
  - Source 2: else wb_data, if wb_reg_write && wb_rd==rsN.
  - Otherwise: the registered data.
- ALU operands:
  - alu_a = ex_a_sel_pc ? ex_pc : fwd_rs1.
  - alu_b = ex_b_sel_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always.
- A stall lasts exactly 1 cycle per load-use pair. A bubble in EX never triggers a stall.

Optional Feature:
- Macro: PRV32_FORWARDING_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - EX forwarding muxes are removed; operands come straight from the registers.
  - stall = id_valid && !flush && (EX hazard || MEM hazard).
    - EX hazard: ex_valid && ex_ctrl[0] && ex_rd!=0 && ex_rd matches id_rs1/id_rs2.
    - MEM hazard: mem_reg_write && mem_rd!=0 && mem_rd matches id_rs1/id_rs2.
  - Up to 2 stall cycles per dependency.
  - Capture-time WB bypass is retained in both builds.

Decomposition:
- defines.v gains the CTRL bit indices (CTRL_REG_WRITE=0, CTRL_MEM_READ=1) and the bubble encoding.
- Sub-module prv32_fwd_sel: one operand's forwarding priority select (address compare, x0 guard, 3:1 mux), instantiated twice.

Test Plan:
1. No-hazard capture: ADD x3,x1,x2 with x1=5, x2=7, alufn=ADD → next cycle ex_valid=1, alu_a=5, alu_b=7, stall=0.
2. EX/MEM forward: mem_rd=1, mem_reg_write=1, mem_result=0x10; with wb_rd=1, wb_data=0x20 also asserted → alu_a=0x10 (EX/MEM wins over MEM/WB).
3. x0 guard: mem_rd=0, mem_reg_write=1, mem_result=0xFFFF, ex rs1=0, registered rs1 data=0 → alu_a=0.
4. Load-use: LW x5 in EX, ADD x6,x5,x1 in ID → stall=1 for exactly 1 cycle, then ex_valid=0 for one cycle; next capture forwards wb_data=0xABCD to alu_a.
5. Flush during stall: load-use condition with flush=1 → stall=0; next cycle ex_valid=0, ex_ctrl=0.
6. Reset mid-stream: rst high with ex_valid=1 → after posedge ex_valid=0, ex_ctrl=0, alu_a=0; with the macro undefined, a RAW on the EX-stage rd gives 2 stall cycles.

Source files
------------

// File: rtl/prv32_id_ex_stage_pkg.sv
// Shared definitions for the RV32 ID/EX stage: control-bundle bit positions,
// the bubble encoding and the forwarding-source select.
package prv32_id_ex_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int RA_W_DEF   = 5;
  localparam int CTRL_W_DEF = 8;

  // Bit positions inside the opaque downstream control bundle
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;

  // A bubble has valid low, an all-zero control bundle and rd = x0
  localparam logic BUBBLE_VALID = 1'b0;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_src_e;

endpackage

// File: rtl/prv32_id_ex_stage_fwd_sel.sv
// prv32_fwd_sel: forwarding select for one EX operand.
// EX/MEM beats MEM/WB beats the registered value; x0 is never forwarded.
// With fwd_en tied low the select collapses to the registered value.
module prv32_fwd_sel
  import prv32_id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            fwd_en,
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data
);

  fwd_src_e src;

  // Pick the youngest in-flight producer of rs
  always_comb begin
    src = FWD_REG;
    if (fwd_en && rs != '0) begin
      if (mem_reg_write && mem_rd == rs)     src = FWD_MEM;
      else if (wb_reg_write && wb_rd == rs)  src = FWD_WB;
    end
  end

  // 3:1 operand mux
  always_comb begin
    case (src)
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/prv32_id_ex_stage.sv
// prv32_id_ex_stage: ID/EX pipeline register feeding the ALU.
// Captures ID operands/control, bypasses WB data at capture, forwards
// EX/MEM and MEM/WB results into the ALU operands, and inserts bubbles
// on load-use stall or branch flush.
// Build option: define PRV32_FORWARDING_EN to enable EX-stage forwarding;
// without it operands come straight from the register and the stage
// interlocks on any EX/MEM RAW dependency instead.
module prv32_id_ex_stage
  import prv32_id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [3:0]        id_alufn,
  input  logic              id_a_sel_pc,
  input  logic              id_b_sel_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [3:0]        ex_alufn,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   ex_store_data
);

`ifdef PRV32_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic [1:0][RA_W-1:0] id_rs, ex_rs;
  logic [1:0][XLEN-1:0] id_rs_data, cap_rs_data, ex_rs_data, fwd_rs;
  logic [XLEN-1:0]      ex_imm;
  logic                 ex_a_sel_pc, ex_b_sel_imm;
  logic                 hazard, bubble;

  assign id_rs      = {id_rs2, id_rs1};
  assign id_rs_data = {id_rs2_data, id_rs1_data};

  // Capture-time WB bypass covers the register-file write/read same-cycle gap
  for (genvar g = 0; g < 2; g++) begin : g_cap
    assign cap_rs_data[g] = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs[g])
                            ? wb_data : id_rs_data[g];
  end

`ifdef PRV32_FORWARDING_EN
  // Only a load in EX cannot be covered by forwarding; rs2 is checked even for imm forms
  assign hazard = id_valid && ex_valid && ex_ctrl[CTRL_MEM_READ] && ex_rd != '0 &&
                  (ex_rd == id_rs1 || ex_rd == id_rs2);
`else
  logic ex_haz, mem_haz;
  // Without forwarding, any producer still in EX or MEM must drain to WB first
  assign ex_haz  = ex_valid && ex_ctrl[CTRL_REG_WRITE] && ex_rd != '0 &&
                   (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign mem_haz = mem_reg_write && mem_rd != '0 &&
                   (mem_rd == id_rs1 || mem_rd == id_rs2);
  assign hazard  = id_valid && (ex_haz || mem_haz);
`endif

  // Flush wins so the fetch redirect is never held
  assign stall  = hazard && !flush;
  assign bubble = flush || stall;

  // Control half of the register: cleared on reset and on any bubble
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid <= BUBBLE_VALID;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_rd    <= id_rd;
    end
  end

  // Data half of the register: cleared on reset, held on a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc        <= '0;
      ex_alufn     <= '0;
      ex_rs        <= '0;
      ex_rs_data   <= '0;
      ex_imm       <= '0;
      ex_a_sel_pc  <= 1'b0;
      ex_b_sel_imm <= 1'b0;
    end else if (!bubble) begin
      ex_pc        <= id_pc;
      ex_alufn     <= id_alufn;
      ex_rs        <= id_rs;
      ex_rs_data   <= cap_rs_data;
      ex_imm       <= id_imm;
      ex_a_sel_pc  <= id_a_sel_pc;
      ex_b_sel_imm <= id_b_sel_imm;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    prv32_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .fwd_en        (FWD_EN),
      .rs            (ex_rs[g]),
      .reg_data      (ex_rs_data[g]),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_data       (wb_data),
      .data          (fwd_rs[g])
    );
  end

  assign alu_a         = ex_a_sel_pc  ? ex_pc  : fwd_rs[0];
  assign alu_b         = ex_b_sel_imm ? ex_imm : fwd_rs[1];
  assign ex_store_data = fwd_rs[1];

endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// Bench for prv32_id_ex_stage: directed vectors push expectations tagged
// with the cycle they apply to; a negedge monitor pops and compares.
module tb_prv32_id_ex_stage;

  localparam int F_STALL = 0, F_VALID = 1, F_CTRL = 2, F_RD = 3, F_A = 4,
                 F_B = 5, F_ST = 6, F_PC = 7, F_FN = 8;

  logic        clk = 1'b0, rst;
  logic        id_valid, id_a_sel_pc, id_b_sel_imm, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alufn;
  logic [7:0]  id_ctrl;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_data;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [3:0]  ex_alufn;

  prv32_id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alufn(id_alufn),
    .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm), .id_ctrl(id_ctrl),
    .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_alufn(ex_alufn), .alu_a(alu_a),
    .alu_b(alu_b), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    int          fld;
    logic [31:0] want;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] pick(input int f);
    case (f)
      F_STALL: pick = {31'b0, stall};
      F_VALID: pick = {31'b0, ex_valid};
      F_CTRL:  pick = {24'b0, ex_ctrl};
      F_RD:    pick = {27'b0, ex_rd};
      F_A:     pick = alu_a;
      F_B:     pick = alu_b;
      F_ST:    pick = ex_store_data;
      F_PC:    pick = ex_pc;
      F_FN:    pick = {28'b0, ex_alufn};
      default: pick = 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle, mid-cycle
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      m_e   = sb.pop_front();
      m_act = pick(m_e.fld);
      n_vec++;
      if (m_e.due != cyc || m_act !== m_e.want) begin
        n_err++;
        $display("FAIL %s (cycle %0d): got %h, want %h", m_e.name, m_e.due, m_act, m_e.want);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int f, input logic [31:0] v);
    sb.push_back('{due: cyc, name: nm, fld: f, want: v});
  endtask

  task automatic idle_id();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alufn = 0; id_a_sel_pc = 0;
    id_b_sel_imm = 0; id_ctrl = 0;
  endtask

  task automatic clr_fwd();
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] fn, input logic asel,
                       input logic bsel, input logic [7:0] ctrl);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_pc = pc; id_alufn = fn;
    id_a_sel_pc = asel; id_b_sel_imm = bsel; id_ctrl = ctrl;
  endtask

  task automatic issue_lw_x5();
    issue(5'd1, 5'd0, 5'd5, 32'h40, 32'h0, 32'h0, 32'h400, 4'h0, 1'b0, 1'b1, 8'h03);
  endtask

  initial begin
    rst = 1; flush = 0;
    idle_id(); clr_fwd();
    repeat (3) step();

    // Reset state
    chk("rst_valid", F_VALID, 0); chk("rst_ctrl", F_CTRL, 0); chk("rst_rd", F_RD, 0);
    chk("rst_a", F_A, 0); chk("rst_b", F_B, 0); chk("rst_st", F_ST, 0);
    chk("rst_pc", F_PC, 0); chk("rst_fn", F_FN, 0); chk("rst_stall", F_STALL, 0);
    step(); rst = 0;

    // 1: no-hazard ADD x3,x1,x2
    step(); issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h100, 4'h0, 1'b0, 1'b0, 8'h01);
    chk("add_stall", F_STALL, 0);
    step(); idle_id();
    chk("add_valid", F_VALID, 1); chk("add_a", F_A, 5); chk("add_b", F_B, 7);
    chk("add_st", F_ST, 7); chk("add_rd", F_RD, 3); chk("add_ctrl", F_CTRL, 8'h01);
    chk("add_pc", F_PC, 32'h100); chk("add_stall2", F_STALL, 0);

    // PC/imm operand selects
    step(); issue(5'd0, 5'd0, 5'd7, 32'h55, 32'h66, 32'h1000, 32'h200, 4'h9, 1'b1, 1'b1, 8'h01);
    step(); idle_id();
    chk("sel_a_pc", F_A, 32'h200); chk("sel_b_imm", F_B, 32'h1000);
    chk("sel_st", F_ST, 32'h66); chk("sel_fn", F_FN, 4'h9);

    // Capture-time WB bypass on rs1 only
    step(); issue(5'd9, 5'd10, 5'd11, 32'h1111, 32'h2222, 32'h0, 32'h300, 4'h0, 1'b0, 1'b0, 8'h01);
    wb_rd = 9; wb_reg_write = 1; wb_data = 32'h9999;
    chk("cap_stall", F_STALL, 0);
    step(); idle_id(); clr_fwd();
    chk("cap_a", F_A, 32'h9999); chk("cap_b", F_B, 32'h2222);

    // 2: EX/MEM wins over MEM/WB on rs1
    step(); clr_fwd(); issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h104, 4'h0, 1'b0, 1'b0, 8'h01);
    step(); idle_id();
    mem_rd = 1; mem_reg_write = 1; mem_result = 32'h10; wb_rd = 1; wb_reg_write = 1; wb_data = 32'h20;
`ifdef PRV32_FORWARDING_EN
    chk("fwd_mem_a", F_A, 32'h10);
`else
    chk("nofwd_mem_a", F_A, 32'd5);
`endif
    chk("fwd_mem_b", F_B, 32'd7); chk("fwd_mem_stall", F_STALL, 0);

    // MEM/WB forward on rs2 while EX/MEM targets another register
    step(); clr_fwd(); issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h108, 4'h0, 1'b0, 1'b0, 8'h01);
    step(); idle_id();
    mem_rd = 5; mem_reg_write = 1; mem_result = 32'hBEEF; wb_rd = 2; wb_reg_write = 1; wb_data = 32'h30;
    chk("fwd_wb_a", F_A, 32'd5);
`ifdef PRV32_FORWARDING_EN
    chk("fwd_wb_b", F_B, 32'h30); chk("fwd_wb_st", F_ST, 32'h30);
`else
    chk("nofwd_wb_b", F_B, 32'd7); chk("nofwd_wb_st", F_ST, 32'd7);
`endif

    // 3: x0 guard at capture and in EX
    step(); clr_fwd(); issue(5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h10C, 4'h0, 1'b0, 1'b0, 8'h01);
    wb_rd = 0; wb_reg_write = 1; wb_data = 32'hEEEE;
    step(); idle_id();
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFFFF; wb_rd = 0; wb_reg_write = 1; wb_data = 32'hEEEE;
    chk("x0_a", F_A, 0); chk("x0_b", F_B, 0);

    // 4: load-use LW x5 ; ADD x6,x5,x1
    step(); clr_fwd(); issue_lw_x5();
    chk("lu_lw_stall", F_STALL, 0);
    step(); issue(5'd5, 5'd1, 5'd6, 32'hDEAD, 32'h40, 32'h0, 32'h404, 4'h0, 1'b0, 1'b0, 8'h01);
    chk("lu_stall", F_STALL, 1); chk("lu_lw_valid", F_VALID, 1);
    chk("lu_lw_rd", F_RD, 5); chk("lu_lw_ctrl", F_CTRL, 8'h03); chk("lu_lw_a", F_A, 32'h40);
    step(); mem_rd = 5; mem_reg_write = 1; mem_result = 32'h0;
    chk("lu_bub_valid", F_VALID, 0); chk("lu_bub_ctrl", F_CTRL, 0); chk("lu_bub_rd", F_RD, 0);
`ifdef PRV32_FORWARDING_EN
    chk("lu_stall_once", F_STALL, 0);
    step(); idle_id(); clr_fwd(); wb_rd = 5; wb_reg_write = 1; wb_data = 32'hABCD;
`else
    chk("lu_stall_mem", F_STALL, 1);
    step(); clr_fwd(); wb_rd = 5; wb_reg_write = 1; wb_data = 32'hABCD;
    chk("lu_bub2_valid", F_VALID, 0); chk("lu_stall_end", F_STALL, 0);
    step(); idle_id(); clr_fwd();
`endif
    chk("lu_add_valid", F_VALID, 1); chk("lu_add_a", F_A, 32'hABCD);
    chk("lu_add_b", F_B, 32'h40); chk("lu_add_rd", F_RD, 6); chk("lu_add_stall", F_STALL, 0);

    // 5: flush during a load-use condition
    step(); clr_fwd(); issue_lw_x5();
    step(); issue(5'd5, 5'd1, 5'd6, 32'h0, 32'h40, 32'h0, 32'h404, 4'h0, 1'b0, 1'b0, 8'h01);
    flush = 1;
    chk("fl_stall", F_STALL, 0);
    step(); flush = 0; idle_id();
    chk("fl_valid", F_VALID, 0); chk("fl_ctrl", F_CTRL, 0); chk("fl_rd", F_RD, 0);

    // rs2 compared even for an immediate-form consumer
    step(); issue_lw_x5();
    step(); issue(5'd1, 5'd5, 5'd6, 32'h40, 32'h0, 32'h7, 32'h404, 4'h0, 1'b0, 1'b1, 8'h01);
    chk("rs2imm_stall", F_STALL, 1);
    step(); idle_id();
    chk("rs2imm_bub", F_VALID, 0); chk("rs2imm_nostall", F_STALL, 0);

    // ALU producer followed by a dependent consumer
    step(); issue(5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 32'h0, 32'h500, 4'h0, 1'b0, 1'b0, 8'h01);
    chk("raw_prod_stall", F_STALL, 0);
    step(); issue(5'd8, 5'd8, 5'd9, 32'hBAD, 32'hBAD, 32'h0, 32'h504, 4'h0, 1'b0, 1'b0, 8'h01);
`ifdef PRV32_FORWARDING_EN
    chk("raw_nostall", F_STALL, 0);
    step(); idle_id(); mem_rd = 8; mem_reg_write = 1; mem_result = 32'h77;
`else
    chk("raw_stall1", F_STALL, 1);
    step(); mem_rd = 8; mem_reg_write = 1; mem_result = 32'h77;
    chk("raw_stall2", F_STALL, 1); chk("raw_bub1", F_VALID, 0);
    step(); clr_fwd(); wb_rd = 8; wb_reg_write = 1; wb_data = 32'h77;
    chk("raw_stall_end", F_STALL, 0); chk("raw_bub2", F_VALID, 0);
    step(); idle_id(); clr_fwd();
`endif
    chk("raw_valid", F_VALID, 1); chk("raw_a", F_A, 32'h77);
    chk("raw_b", F_B, 32'h77); chk("raw_st", F_ST, 32'h77);

    // 6: reset mid-stream
    step(); clr_fwd(); issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h600, 4'h0, 1'b0, 1'b0, 8'h01);
    step(); idle_id(); rst = 1;
    chk("mid_pre_valid", F_VALID, 1); chk("mid_pre_pc", F_PC, 32'h600);
    step(); rst = 0;
    chk("mid_valid", F_VALID, 0); chk("mid_ctrl", F_CTRL, 0); chk("mid_a", F_A, 0);
    chk("mid_b", F_B, 0); chk("mid_pc", F_PC, 0); chk("mid_rd", F_RD, 0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    step();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
